mult_hilo_unit: RTL

//  - Multi-cycle sequencer and HI/LO register pair that consumes the 64-bit product of the

---
 rtl/mult_hilo_unit_pkg.sv | 33 +++
 rtl/mult_hilo_unit_if.sv | 16 +
 rtl/mult_hilo_unit_core_sel.sv | 43 ++++
 rtl/mult_hilo_unit.sv | 131 +++++++++++++
 4 files changed

// File: rtl/mult_hilo_unit_pkg.sv
// Shared definitions for the HI/LO multiply unit: op codes, FSM states, default width.
// MULT_HILO_MACC_EN enables the MADD/MADDU accumulate ops.
package mult_hilo_unit_pkg;

   localparam int MULT_DATA_WIDTH = 32;

   localparam logic [2:0] MULT_OP_MUL   = 3'b000;
   localparam logic [2:0] MULT_OP_MULU  = 3'b001;
   localparam logic [2:0] MULT_OP_MTHI  = 3'b010;
   localparam logic [2:0] MULT_OP_MTLO  = 3'b011;
   localparam logic [2:0] MULT_OP_MADD  = 3'b100;
   localparam logic [2:0] MULT_OP_MADDU = 3'b101;

   typedef enum logic {
      MULT_ST_IDLE = 1'b0,
      MULT_ST_WAIT = 1'b1
   } mult_state_e;

   // True for op codes that start a multi-cycle multiply.
   function automatic logic is_mult_op(input logic [2:0] op);
      logic r;
      r = 1'b0;
      case (op)
         MULT_OP_MUL, MULT_OP_MULU: r = 1'b1;
`ifdef MULT_HILO_MACC_EN
         MULT_OP_MADD, MULT_OP_MADDU: r = 1'b1;
`endif
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mult_hilo_unit_if.sv
// Request/response bundle between the execute stage and the HI/LO multiply unit.
interface mult_hilo_unit_if #(
   parameter int DATA_WIDTH = mult_hilo_unit_pkg::MULT_DATA_WIDTH
);
   logic                  start;
   logic [2:0]            op;
   logic [DATA_WIDTH-1:0] a;
   logic [DATA_WIDTH-1:0] b;
   logic                  busy;
   logic                  done;
   logic [DATA_WIDTH-1:0] hi;
   logic [DATA_WIDTH-1:0] lo;

   modport master (output start, op, a, b, input busy, done, hi, lo);
   modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mult_hilo_unit_core_sel.sv
// Signed and unsigned array multipliers fed from the registered operands,
// with the product selected by the registered signedness bit.
module MULT32 #(
   parameter int W = 32
) (
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic [2*W-1:0] p
);
   logic signed [2*W-1:0] a_ext;
   logic signed [2*W-1:0] b_ext;

   assign a_ext = {{W{a[W-1]}}, a};
   assign b_ext = {{W{b[W-1]}}, b};
   assign p     = a_ext * b_ext;
endmodule

module MULT32_U #(
   parameter int W = 32
) (
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic [2*W-1:0] p
);
   assign p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
endmodule

module mult_core_sel #(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0]   opa,
   input  logic [DATA_WIDTH-1:0]   opb,
   input  logic                    is_signed,
   output logic [2*DATA_WIDTH-1:0] product
);
   logic [2*DATA_WIDTH-1:0] prod_s;
   logic [2*DATA_WIDTH-1:0] prod_u;

   MULT32 #(.W(DATA_WIDTH)) u_mult_s (.a(opa), .b(opb), .p(prod_s));
   MULT32_U #(.W(DATA_WIDTH)) u_mult_u (.a(opa), .b(opb), .p(prod_u));

   assign product = is_signed ? prod_s : prod_u;
endmodule

// File: rtl/mult_hilo_unit.sv
// Multi-cycle multiply sequencer with architectural HI/LO registers and MTHI/MTLO writes.
// Define MULT_HILO_MACC_EN to add MADD/MADDU (accumulate into {HI,LO}).
module mult_hilo_unit
   import mult_hilo_unit_pkg::*;
#(
   parameter int DATA_WIDTH = MULT_DATA_WIDTH,
   parameter int MULT_LAT   = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   mult_hilo_unit_if.slave mbus
);
   localparam int CW = $clog2(MULT_LAT + 1);

   mult_state_e             state_reg, state_next;
   logic [CW-1:0]           cnt_reg, cnt_next;
   logic [DATA_WIDTH-1:0]   opa_reg, opb_reg;
   logic                    signed_reg;
   logic [DATA_WIDTH-1:0]   hi_reg, hi_next;
   logic [DATA_WIDTH-1:0]   lo_reg, lo_next;
   logic                    done_reg, done_next;
   logic [2*DATA_WIDTH-1:0] product;
   logic [2*DATA_WIDTH-1:0] capture_val;
   logic                    idle_req, accept, wr_hi, wr_lo, capture;
`ifdef MULT_HILO_MACC_EN
   logic                    acc_reg;
`endif

   assign idle_req = (state_reg == MULT_ST_IDLE) && mbus.start;
   assign accept   = idle_req && is_mult_op(mbus.op);
   assign wr_hi    = idle_req && (mbus.op == MULT_OP_MTHI);
   assign wr_lo    = idle_req && (mbus.op == MULT_OP_MTLO);
   assign capture  = (state_reg == MULT_ST_WAIT) && (cnt_reg == CW'(1));

   // Core sees only the held operands, so A/B may change freely during WAIT.
   mult_core_sel #(.DATA_WIDTH(DATA_WIDTH)) u_core (
      .opa       (opa_reg),
      .opb       (opb_reg),
      .is_signed (signed_reg),
      .product   (product)
   );

`ifdef MULT_HILO_MACC_EN
   assign capture_val = acc_reg ? ({hi_reg, lo_reg} + product) : product;
`else
   assign capture_val = product;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= MULT_ST_IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         MULT_ST_IDLE: begin
            if (accept) begin
               state_next = MULT_ST_WAIT;
               cnt_next   = CW'(MULT_LAT);
            end
         end
         MULT_ST_WAIT: begin
            if (cnt_reg == CW'(1)) begin
               state_next = MULT_ST_IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg - CW'(1);
            end
         end
         default: begin
            state_next = MULT_ST_IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   always_comb begin
      hi_next   = hi_reg;
      lo_next   = lo_reg;
      done_next = 1'b0;
      if (capture) begin
         {hi_next, lo_next} = capture_val;
         done_next          = 1'b1;
      end else if (wr_hi) begin
         hi_next   = mbus.a;
         done_next = 1'b1;
      end else if (wr_lo) begin
         lo_next   = mbus.a;
         done_next = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_reg     <= '0;
         lo_reg     <= '0;
         done_reg   <= 1'b0;
         opa_reg    <= '0;
         opb_reg    <= '0;
         signed_reg <= 1'b0;
`ifdef MULT_HILO_MACC_EN
         acc_reg    <= 1'b0;
`endif
      end else begin
         hi_reg   <= hi_next;
         lo_reg   <= lo_next;
         done_reg <= done_next;
         if (accept) begin
            opa_reg    <= mbus.a;
            opb_reg    <= mbus.b;
            signed_reg <= ~mbus.op[0];
`ifdef MULT_HILO_MACC_EN
            acc_reg    <= mbus.op[2];
`endif
         end
      end
   end

   assign mbus.busy = (state_reg == MULT_ST_WAIT);
   assign mbus.done = done_reg;
   assign mbus.hi   = hi_reg;
   assign mbus.lo   = lo_reg;

endmodule
